// File: rtl/capture_ctrl.sv
// Capture sequencer: merges enabled trigger pulses and steps a circular sample-RAM
// write pointer through pre-fill, armed and post-trigger phases, then reports the oldest slot.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          abort,
    input  logic          wrt_smpl,
    input  logic          SPItrig,
    input  logic          UARTtrig,
    input  logic [4:0]    chTrig,
    input  logic [6:0]    trig_cfg,
    input  logic [AW-1:0] trig_pos,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          armed,
    output logic          triggered,
    output logic          capture_done,
    output logic [AW-1:0] start_addr
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;

    state_t r_state, w_state_nxt;
    addr_t  r_waddr, r_post_cnt, r_start_addr;
    cnt_t   r_pre_cnt;
    logic   r_armed, r_triggered, r_done;

    logic   w_trig_any, w_we, w_restart, w_abort, w_arm, w_trig, w_done;
    addr_t  w_waddr_inc;
    cnt_t   w_fill_target, w_pre_inc;

    assign w_trig_any    = |(trig_cfg & {SPItrig, UARTtrig, chTrig});
    assign w_waddr_inc   = (r_waddr == addr_t'(ENTRIES - 1)) ? '0 : r_waddr + addr_t'(1);
    // Pre-trigger region size; computed one bit wider so ENTRIES itself is representable.
    assign w_fill_target = cnt_t'(ENTRIES) - {1'b0, trig_pos};
    assign w_pre_inc     = r_pre_cnt + cnt_t'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_restart   = 1'b0;
        w_abort     = 1'b0;
        w_arm       = 1'b0;
        w_trig      = 1'b0;
        w_done      = 1'b0;
        if (abort) begin
            w_abort     = 1'b1;
            w_state_nxt = S_IDLE;
        end else if (run) begin
            w_restart   = 1'b1;
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    w_we = wrt_smpl;
                    if (wrt_smpl && (w_pre_inc == w_fill_target)) begin
                        w_arm       = 1'b1;
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    w_we = wrt_smpl;
                    if (w_trig_any) begin
                        w_trig = 1'b1;
                        if (trig_pos == '0) begin
                            w_done      = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_POST;
                        end
                    end
                end
                S_POST: begin
                    w_we = wrt_smpl;
                    if (wrt_smpl && ((r_post_cnt + addr_t'(1)) == trig_pos)) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr      <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_start_addr <= '0;
            r_armed      <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_abort) begin
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_restart) begin
            r_waddr     <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_we) begin
                r_waddr <= w_waddr_inc;
                // The write in the trigger cycle still counts as pre-trigger.
                if (r_state == S_POST)
                    r_post_cnt <= r_post_cnt + addr_t'(1);
                else if (r_pre_cnt != cnt_t'(ENTRIES))
                    r_pre_cnt <= w_pre_inc;
            end
            if (w_arm)  r_armed     <= 1'b1;
            if (w_trig) r_triggered <= 1'b1;
            if (w_done) begin
                r_done       <= 1'b1;
                r_start_addr <= w_we ? w_waddr_inc : r_waddr;
            end
        end
    end

    assign we           = w_we;
    assign waddr        = r_waddr;
    assign armed        = r_armed;
    assign triggered    = r_triggered;
    assign capture_done = r_done;
    assign start_addr   = r_start_addr;

endmodule
